// File: rtl/binary_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one shift per clock.
// Optional leading-zero blanking of the hundreds/tens digits: define LEADING_ZERO_BLANK_EN.
module binary_to_bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
);

  typedef enum logic {IDLE, SHIFT} state_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] RST_D2 = 4'hF;
  localparam logic [3:0] RST_D1 = 4'hF;
`else
  localparam logic [3:0] RST_D2 = 4'h0;
  localparam logic [3:0] RST_D1 = 4'h0;
`endif
  localparam logic [3:0] RST_D0 = 4'h0;

  state_t      state;
  logic [3:0]  cnt;
  logic [19:0] scratch;
  logic [19:0] adjusted;
  logic [19:0] shifted;
  logic [3:0]  load_d2;
  logic [3:0]  load_d1;

  // Add-3 correction on each BCD nibble, then the one-bit left shift.
  always_comb begin
    // NOTE: assign a default first so every path writes the signal and no latch is inferred.
    adjusted = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[8 + 4*i +: 4] >= 4'd5)
        adjusted[8 + 4*i +: 4] = scratch[8 + 4*i +: 4] + 4'd3;
    end
    shifted = {adjusted[18:0], 1'b0};
  end

  // Digits as loaded on the final iteration; 4'hF blanks the digit at the decoder.
  always_comb begin
    load_d2 = shifted[19:16];
    load_d1 = shifted[15:12];
`ifdef LEADING_ZERO_BLANK_EN
    if (shifted[19:16] == 4'd0) begin
      load_d2 = 4'hF;
      if (shifted[15:12] == 4'd0)
        load_d1 = 4'hF;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      scratch <= 20'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd2    <= RST_D2;
      bcd1    <= RST_D1;
      bcd0    <= RST_D0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {12'd0, bin};
            cnt     <= 4'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            bcd2  <= load_d2;
            bcd1  <= load_d1;
            bcd0  <= shifted[11:8];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: conversion request, sampled on rising clk.
REQ-004 The block SHALL have the port bin, input, 8 bits: unsigned binary operand, sampled with start.
REQ-005 The block SHALL have the port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the result registers update.
REQ-007 The block SHALL have the port bcd2, output, 4 bits: hundreds digit.
REQ-008 The block SHALL have the port bcd1, output, 4 bits: tens digit.
REQ-009 The block SHALL have the port bcd0, output, 4 bits: ones digit.
REQ-010 bcd2, bcd1 and bcd0 SHALL be registered outputs that feed the downstream 7-segment digit decoders directly.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and SHIFT, with a 4-bit iteration counter and a 20-bit scratch register (12 BCD bits plus 8 operand bits).
REQ-012 In IDLE, start=1 at edge N SHALL latch bin into the scratch register with the BCD field cleared, clear the counter, and enter SHIFT.
REQ-013 In IDLE, start=0 SHALL leave all state unchanged.
REQ-014 In SHIFT, each edge SHALL add 3 to every BCD nibble that is >=5, then shift the whole scratch register left by 1, then increment the counter.
REQ-015 On edges N+1 through N+8 the block SHALL perform exactly 8 shift iterations.
REQ-016 At edge N+8 the block SHALL load bcd2, bcd1 and bcd0 from the final scratch nibbles, set done=1, and return to IDLE.
REQ-017 done SHALL be high for exactly the one cycle following edge N+8.
REQ-018 busy SHALL equal (state==SHIFT): high in the cycles after edges N through N+7 and low in the cycle where done=1.
REQ-019 start SHALL be ignored while in SHIFT, and changes on bin during SHIFT SHALL have no effect.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted, since the FSM is then in IDLE; back-to-back conversions therefore take 9 cycles each.
REQ-021 bcd2, bcd1 and bcd0 SHALL hold the last result until the next completion and SHALL NOT change during SHIFT.
REQ-022 Every valid result digit SHALL be in the range 0..9, with bcd2 <= 2 for any 8-bit input.

Reset
REQ-023 rst=1 SHALL, asynchronously and regardless of state (including mid-conversion), force IDLE, counter=0, scratch=0, busy=0 and done=0.
REQ-024 rst=1 SHALL force bcd2, bcd1 and bcd0 to their reset values per REQ-027.
REQ-025 An aborted conversion SHALL produce no done pulse.
REQ-026 After rst deasserts, the first start SHALL be handled as in REQ-012.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking:
- Defined: at result load, bcd2 = 4'hF if the hundreds digit is 0; bcd1 = 4'hF if both hundreds and tens are 0; bcd0 is never blanked. Reset values are bcd2=4'hF, bcd1=4'hF, bcd0=4'h0. 4'hF drives the downstream decoder's all-segments-off default.
- Undefined: raw digits are always output, and reset values are 0/0/0.
REQ-028 Blanking SHALL NOT affect latency, busy or done timing.

Verification
REQ-029 Scenario: rst pulse, then start with bin=255 at edge N -> busy high for 8 cycles, done pulse after edge N+8, digits 2/5/5.
REQ-030 Scenario: bin=109 -> digits 1/0/9; the inner zero is never blanked, with or without the macro.
REQ-031 Scenario: bin=0 -> digits 0/0/0 without the macro; F/F/0 with LEADING_ZERO_BLANK_EN.
REQ-032 Scenario: bin=7 with the macro -> F/F/7.
REQ-033 Scenario: start with bin=42, then start held high with bin=200 through SHIFT -> result 0/4/2 and the second request is ignored; start=1 with bin=200 during the done cycle -> 2/0/0 nine cycles later.
REQ-034 Scenario: rst asserted at edge N+4 of a conversion of 255 -> immediate busy=0, no done pulse, reset digit values, and the previous result discarded.
